id_ex_hazard_ctrl: RTL and testbench
====================================

# id_ex_hazard_ctrl

Pipeline hazard controller that sequences the ID/EX pipeline register and the stages around it. It detects integer/FP load-use hazards and holds the EX stage for multicycle FP/divide operations with a countdown FSM. It also freezes the pipeline during AXI data-port waits and squashes wrong-path instructions on an EX-resolved redirect. It sits between decode, the EX multicycle units and the AXI memory interface, and drives every stall and flush enable for the F, D and E pipeline registers.

## Interface
Parameters:
- LAT_W, 6, width of the multicycle latency field and of the countdown counter
- PERF_W, 32, width of each performance counter (used only with the counter feature compiled in)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- Rs1D, Rs2D, Rs3D  in  5 each  source register indices in D
- src1_is_floatD, src2_is_floatD, src3_is_floatD  in  1 each  source reads the FP register file
- RdE  in  5  destination register of the instruction in E
- MemReadE  in  1  instruction in E is a load
- RegWriteE, RegFWriteE  in  1 each  E writes the integer / FP register file
- mc_startE  in  1  instruction in E is a multicycle op
- mc_latE  in  LAT_W  total EX latency of that op, in cycles
- mem_busy  in  1  AXI data port has not completed the current access
- pc_redirectE  in  1  branch taken or jump resolved in E
- StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE  out  1 each  clear IF/ID and ID/EX
- mc_busy  out  1  FSM is in MC
- perf_lu_cnt, perf_mc_cnt, perf_mem_cnt  out  PERF_W each  stall-cycle counters

## Operation
- FSM states: RUN and MC. A down-counter `cnt` of width LAT_W supports MC.
- Load-use hazard `lu` is true when MemReadE is 1 and either of these holds for some source i:
  - RegWriteE=1, the source is integer, Rsi==RdE, and RdE≠0.
  - RegFWriteE=1, the source is FP, and Rsi==RdE. f0 is a valid match.
- Multicycle op:
  - In RUN with mc_startE=1 and mc_latE≥2, the block stalls this cycle, loads cnt=mc_latE−2 and moves to MC.
  - mc_latE of 0 or 1 causes no stall.
  - In MC, the multicycle stall `mcs` is (cnt≠0) and cnt decrements each cycle.
  - When cnt==0 and mem_busy==0, the next state is RUN.
  - mc_startE is ignored in MC. This prevents the held instruction from retriggering.
- Output equations:
  - StallE = mem_busy | mcs
  - StallF = StallD = StallE | (lu & ~pc_redirectE)
  - FlushD = pc_redirectE & ~StallE
  - FlushE = (pc_redirectE | lu) & ~StallE
- Priority, highest first: mem_busy, then multicycle, then redirect, then load-use.
  - While StallE is asserted, a pending redirect waits and stays asserted from E.
  - When redirect and load-use occur together, the redirect wins and no stall is applied.

## Timing
- All stall and flush outputs are combinational from state and inputs, valid in the same cycle.
- All outputs are 0 while reset is low. Reset sets the state to RUN, cnt to 0, mc_busy to 0 and all counters to 0.
- Reset asserted in MC aborts the countdown immediately.
- A multicycle op with latency L seen in RUN at cycle N asserts StallE for cycles N through N+L−2, which is L−1 cycles. StallE is released at N+L−1 unless mem_busy is high.
- The counter keeps decrementing while mem_busy is high. The FSM stays in MC at cnt==0 until mem_busy drops.
- Load-use inserts exactly one bubble: one cycle of StallF/StallD together with FlushE.
- mc_busy is registered and reflects the state.

## Configuration
- Macro HAZARD_PERF_CNT_EN:
  - Defined: three saturating counters of width PERF_W, each incrementing once per cycle:
    - perf_lu_cnt on cycles where lu & ~pc_redirectE & ~StallE
    - perf_mc_cnt on cycles where mcs
    - perf_mem_cnt on cycles where mem_busy
  - Not defined: the three perf ports remain and are tied to 0, and no counter flops are generated.

## Structure
- A shared control package or header holds:
  - the state encodings RUN=1'b0 and MC=1'b1
  - the LAT_W default
  - the perf counter width
- One sub-module, hazard_mc_countdown, holds the MC FSM and counter. Its outputs are mcs and mc_busy; its inputs are mc_startE, mc_latE and mem_busy.
- Load-use compare logic and the output equations stay in the top module.

## Test plan
- Load-use: load x5 in E (RegWriteE=1, MemReadE=1), Rs1D=5 integer source -> one cycle of StallF=StallD=FlushE=1 with StallE=0. The same case with RdE=0 -> no stall.
- FP load-use and f0: FLW f0 in E (RegFWriteE=1), src2_is_floatD=1, Rs2D=0 -> stall plus flush. The same with src2_is_floatD=0 -> no stall.
- Multicycle: mc_startE=1, mc_latE=5 at cycle N -> StallE high for cycles N..N+3 and low at N+4. mc_busy=1 for cycles N+1..N+4. mc_latE=1 -> no stall.
- mem_busy during MC: mc_latE=3 with mem_busy held high for 6 cycles -> StallE=1 for 6 cycles. The FSM stays in MC until mem_busy drops, then returns to RUN with no retrigger.
- Redirect vs. load-use and stall:
  - pc_redirectE and lu in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
  - Redirect during MC -> no flush until StallE drops.
- Reset mid-MC, with HAZARD_PERF_CNT_EN defined: reset low during countdown -> all outputs 0, state RUN, counters 0. After release, perf_mc_cnt counts only the new stall cycles.

Source files
------------

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared control definitions for the ID/EX hazard controller: FSM encodings and
// default widths used by the top, its interface and the countdown sub-module.
package id_ex_hazard_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        MC  = 1'b1
    } hz_state_e;

    localparam int LAT_W_DEF  = 6;
    localparam int PERF_W_DEF = 32;

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Bundle of decode/EX/memory status inputs and stall/flush/perf outputs of the
// hazard controller. The master side drives hazard sources, the slave is the controller.
interface id_ex_hazard_ctrl_if
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int LAT_W  = LAT_W_DEF,
    parameter int PERF_W = PERF_W_DEF
);

    logic [4:0]        Rs1D, Rs2D, Rs3D;
    logic              src1_is_floatD, src2_is_floatD, src3_is_floatD;
    logic [4:0]        RdE;
    logic              MemReadE;
    logic              RegWriteE, RegFWriteE;
    logic              mc_startE;
    logic [LAT_W-1:0]  mc_latE;
    logic              mem_busy;
    logic              pc_redirectE;

    logic              StallF, StallD, StallE;
    logic              FlushD, FlushE;
    logic              mc_busy;
    logic [PERF_W-1:0] perf_lu_cnt, perf_mc_cnt, perf_mem_cnt;

    modport master (
        output Rs1D, Rs2D, Rs3D, src1_is_floatD, src2_is_floatD, src3_is_floatD,
        output RdE, MemReadE, RegWriteE, RegFWriteE, mc_startE, mc_latE,
        output mem_busy, pc_redirectE,
        input  StallF, StallD, StallE, FlushD, FlushE, mc_busy,
        input  perf_lu_cnt, perf_mc_cnt, perf_mem_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs3D, src1_is_floatD, src2_is_floatD, src3_is_floatD,
        input  RdE, MemReadE, RegWriteE, RegFWriteE, mc_startE, mc_latE,
        input  mem_busy, pc_redirectE,
        output StallF, StallD, StallE, FlushD, FlushE, mc_busy,
        output perf_lu_cnt, perf_mc_cnt, perf_mem_cnt
    );

endinterface

// File: rtl/id_ex_hazard_ctrl_mc_countdown.sv
// RUN/MC countdown FSM that holds EX for multicycle ops; mc_busy exposes the
// registered state, mcs is the combinational multicycle stall.
module hazard_mc_countdown
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mc_startE,
    input  logic [LAT_W-1:0] mc_latE,
    input  logic             mem_busy,
    output logic             mcs,
    output logic             mc_busy
);

    hz_state_e        r_state, w_state_nxt;
    logic [LAT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_start;

    // Latencies of 0 or 1 complete within the issuing cycle and never stall.
    assign w_start = mc_startE && (mc_latE >= LAT_W'(2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_start) begin
                    w_state_nxt = MC;
                    w_cnt_nxt   = mc_latE - LAT_W'(2);
                end
            end
            MC: begin
                if (r_cnt != '0)
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                else if (!mem_busy)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        mcs = 1'b0;
        case (r_state)
            RUN:     mcs = reset && w_start;
            MC:      mcs = reset && (r_cnt != '0);
            default: mcs = 1'b0;
        endcase
    end

    assign mc_busy = (r_state == MC);

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use detection, stall/flush priority and optional
// stall-cycle counters (compiled in with HAZARD_PERF_CNT_EN).
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int LAT_W  = LAT_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    id_ex_hazard_ctrl_if.slave  hz
);

    logic       w_mcs, w_lu, w_redir, w_mem_busy, w_stall_e;
    logic [2:0] w_int_hit, w_fp_hit;

    hazard_mc_countdown #(.LAT_W(LAT_W)) u_mc_countdown (
        .clk       (clk),
        .reset     (reset),
        .mc_startE (hz.mc_startE),
        .mc_latE   (hz.mc_latE),
        .mem_busy  (hz.mem_busy),
        .mcs       (w_mcs),
        .mc_busy   (hz.mc_busy)
    );

    // x0 is hardwired, but f0 is a real FP register and must match.
    assign w_int_hit[0] = hz.RegWriteE  && !hz.src1_is_floatD && (hz.Rs1D == hz.RdE) && (hz.RdE != 5'd0);
    assign w_int_hit[1] = hz.RegWriteE  && !hz.src2_is_floatD && (hz.Rs2D == hz.RdE) && (hz.RdE != 5'd0);
    assign w_int_hit[2] = hz.RegWriteE  && !hz.src3_is_floatD && (hz.Rs3D == hz.RdE) && (hz.RdE != 5'd0);
    assign w_fp_hit[0]  = hz.RegFWriteE &&  hz.src1_is_floatD && (hz.Rs1D == hz.RdE);
    assign w_fp_hit[1]  = hz.RegFWriteE &&  hz.src2_is_floatD && (hz.Rs2D == hz.RdE);
    assign w_fp_hit[2]  = hz.RegFWriteE &&  hz.src3_is_floatD && (hz.Rs3D == hz.RdE);

    assign w_lu       = reset && hz.MemReadE && ((|w_int_hit) || (|w_fp_hit));
    assign w_redir    = reset && hz.pc_redirectE;
    assign w_mem_busy = reset && hz.mem_busy;
    assign w_stall_e  = w_mem_busy || w_mcs;

    // A redirect squashes the dependent instruction, so it overrides the load-use stall.
    assign hz.StallE = w_stall_e;
    assign hz.StallF = w_stall_e || (w_lu && !w_redir);
    assign hz.StallD = w_stall_e || (w_lu && !w_redir);
    assign hz.FlushD = w_redir && !w_stall_e;
    assign hz.FlushE = (w_redir || w_lu) && !w_stall_e;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_lu_cnt, r_mc_cnt, r_mem_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lu_cnt  <= '0;
            r_mc_cnt  <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_lu && !w_redir && !w_stall_e && (r_lu_cnt != '1))
                r_lu_cnt <= r_lu_cnt + PERF_W'(1);
            if (w_mcs && (r_mc_cnt != '1))
                r_mc_cnt <= r_mc_cnt + PERF_W'(1);
            if (w_mem_busy && (r_mem_cnt != '1))
                r_mem_cnt <= r_mem_cnt + PERF_W'(1);
        end
    end

    assign hz.perf_lu_cnt  = r_lu_cnt;
    assign hz.perf_mc_cnt  = r_mc_cnt;
    assign hz.perf_mem_cnt = r_mem_cnt;
`else
    assign hz.perf_lu_cnt  = {PERF_W{1'b0}};
    assign hz.perf_mc_cnt  = {PERF_W{1'b0}};
    assign hz.perf_mem_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_id_ex_hazard_ctrl;
    import id_ex_hazard_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // Entry: {chk_perf, lu_cnt, mc_cnt, mem_cnt, StallF, StallD, StallE, FlushD, FlushE, mc_busy}
    logic [102:0] exp_q[$];
    string        name_q[$];

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_MC_AFTER = 32'd3;
`else
    localparam logic [31:0] EXP_MC_AFTER = 32'd0;
`endif

    id_ex_hazard_ctrl_if #(.LAT_W(6), .PERF_W(32)) hz ();

    id_ex_hazard_ctrl #(.LAT_W(6), .PERF_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clr();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs3D = 5'd0;
        hz.src1_is_floatD = 1'b0; hz.src2_is_floatD = 1'b0; hz.src3_is_floatD = 1'b0;
        hz.RdE = 5'd0; hz.MemReadE = 1'b0; hz.RegWriteE = 1'b0; hz.RegFWriteE = 1'b0;
        hz.mc_startE = 1'b0; hz.mc_latE = 6'd0; hz.mem_busy = 1'b0; hz.pc_redirectE = 1'b0;
    endtask

    // Inputs are already applied; record the expectation for this cycle and advance.
    task automatic cyc(input logic [5:0] ctrl, input string nm);
        exp_q.push_back({1'b0, 96'd0, ctrl});
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic cyc_perf(input logic [5:0] ctrl, input logic [31:0] lu,
                            input logic [31:0] mc, input logic [31:0] mem, input string nm);
        exp_q.push_back({1'b1, lu, mc, mem, ctrl});
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic mc_op(input logic [5:0] lat);
        hz.mc_startE = 1'b1;
        hz.mc_latE   = lat;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [102:0] e;
            logic [5:0]   act;
            logic [95:0]  perf;
            string        nm;
            e    = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.mc_busy};
            n_cmp++;
            if (act !== e[5:0]) begin
                n_err++;
                $display("FAIL %s: got SF,SD,SE,FD,FE,busy=%b want %b", nm, act, e[5:0]);
            end
            if (e[102]) begin
                perf = {hz.perf_lu_cnt, hz.perf_mc_cnt, hz.perf_mem_cnt};
                n_cmp++;
                if (perf !== e[101:6]) begin
                    n_err++;
                    $display("FAIL %s_perf: got lu/mc/mem=%0d/%0d/%0d want %0d/%0d/%0d", nm,
                             perf[95:64], perf[63:32], perf[31:0], e[101:70], e[69:38], e[37:6]);
                end
            end
        end
    end

    initial begin
        clr();
        reset = 1'b0;
        @(posedge clk); #1;
        cyc_perf(6'b000000, 32'd0, 32'd0, 32'd0, "reset_idle");
        hz.mem_busy = 1'b1; hz.MemReadE = 1'b1; hz.RegWriteE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
        cyc(6'b000000, "reset_masks_inputs");
        clr();
        reset = 1'b1;
        cyc(6'b000000, "idle");

        // Integer load-use, then x0 destination.
        hz.MemReadE = 1'b1; hz.RegWriteE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
        cyc(6'b110010, "lu_int");
        clr();
        cyc(6'b000000, "lu_int_one_bubble");
        hz.MemReadE = 1'b1; hz.RegWriteE = 1'b1; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
        cyc(6'b000000, "lu_x0");

        // FP load to f0, FP source versus integer source.
        clr();
        hz.MemReadE = 1'b1; hz.RegFWriteE = 1'b1; hz.RdE = 5'd0; hz.Rs1D = 5'd7;
        hz.Rs2D = 5'd0; hz.src2_is_floatD = 1'b1;
        cyc(6'b110010, "lu_fp_f0");
        hz.src2_is_floatD = 1'b0;
        cyc(6'b000000, "lu_fp_int_src");

        // Redirect together with load-use.
        clr();
        hz.MemReadE = 1'b1; hz.RegWriteE = 1'b1; hz.RdE = 5'd9; hz.Rs3D = 5'd9;
        hz.pc_redirectE = 1'b1;
        cyc(6'b000110, "redirect_beats_lu");

        // Latency 5: StallE N..N+3, mc_busy N+1..N+4.
        clr(); mc_op(6'd5);
        cyc(6'b111000, "mc5_n");
        for (int i = 1; i <= 3; i++) cyc(6'b111001, "mc5_count");
        cyc(6'b000001, "mc5_release");
        clr();
        cyc(6'b000000, "mc5_run");

        mc_op(6'd1);
        cyc(6'b000000, "mc_lat1");
        mc_op(6'd0);
        cyc(6'b000000, "mc_lat0");

        // Latency 3 with mem_busy high for 6 cycles; mc_startE stays held in E.
        clr(); mc_op(6'd3); hz.mem_busy = 1'b1;
        cyc(6'b111000, "mcmem_n");
        for (int i = 1; i <= 5; i++) cyc(6'b111001, "mcmem_hold");
        hz.mem_busy = 1'b0;
        cyc(6'b000001, "mcmem_drop");
        clr();
        cyc(6'b000000, "mcmem_no_retrigger");

        // Redirect while multicycle-stalled waits for StallE to drop.
        mc_op(6'd3);
        cyc(6'b111000, "redir_mc_n");
        hz.pc_redirectE = 1'b1;
        cyc(6'b111001, "redir_mc_held");
        cyc(6'b000111, "redir_mc_flush");
        clr();
        cyc(6'b000000, "redir_mc_done");

        // Reset in the middle of a countdown.
        mc_op(6'd5);
        cyc(6'b111000, "rst_mc_n");
        cyc(6'b111001, "rst_mc_count");
        reset = 1'b0; hz.mem_busy = 1'b1;
        cyc(6'b000000, "rst_mc_abort");
        cyc(6'b000000, "rst_mc_hold");
        clr();
        reset = 1'b1;
        cyc_perf(6'b000000, 32'd0, 32'd0, 32'd0, "rst_mc_cleared");

        // Fresh latency-4 op: mcs on N, N+1, N+2.
        mc_op(6'd4);
        cyc(6'b111000, "mc4_n");
        cyc(6'b111001, "mc4_c2");
        cyc(6'b111001, "mc4_c1");
        cyc(6'b000001, "mc4_release");
        clr();
        cyc_perf(6'b000000, 32'd0, EXP_MC_AFTER, 32'd0, "mc4_perf");

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
